bitstream_window_arbiter: RTL and testbench

Shared bit-window front end between the RBSP byte stream and the syntax parsers (VPS/SPS/PPS, slice header, RPS, slice data). It buffers incoming bytes in a left-aligned bit window and lets several parser units consume bits from it. Each grant consumes a forward length of 0–15 bits, and round-robin arbitration ensures exactly one consumer advances the bit pointer per cycle. The block also performs byte alignment, window clear on NAL change, and end-of-stream padding.

---
 rtl/bitstream_window_arbiter.sv | 139 +++++++++++++
 tb/tb_bitstream_window_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_window_arbiter.sv
// Shared bit window between the RBSP byte stream and the syntax parsers.
// Round-robin picks one consumer per cycle to advance the bit pointer.
module bitstream_window_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIN     = 64,
    localparam int LW     = $clog2(WIN) + 1,
    localparam int PW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic                 o_byte_ready,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [4*NUM_REQ-1:0] i_len,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [31:0]          o_window,
    output logic                 o_window_valid,
    output logic [LW-1:0]        o_level,
    input  logic                 i_align,
    input  logic                 i_clear,
    input  logic                 i_eos,
    output logic                 o_underrun,
    output logic [31:0]          o_bits_consumed
);

    typedef enum logic {RUN, EOS} state_e;

    state_e          state_q, state_d;
    logic [WIN-1:0]  win_q, win_d;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic            under_q, under_d;
    logic [31:0]     cons_q, cons_d;

    logic                eos_seen;
    logic [NUM_REQ-1:0]  elig, short_req;
    logic                found;
    logic [PW-1:0]       gidx, cand;
    logic [3:0]          glen;
    logic                push;
    logic [LW-1:0]       sh, rem;
    logic [WIN-1:0]      win_sh, ins;
    logic [31:0]         top, mask;

    assign eos_seen = (state_q == EOS);

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = i_req[k] && (LW'(i_len[4*k +: 4]) <= level_q)
                      && en && !rst && !i_align && !i_clear;
            short_req[k] = i_req[k] && (LW'(i_len[4*k +: 4]) > level_q);
        end
    end

    // Search starts one past the last winner so every consumer gets a turn.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(rr_q) + i) % NUM_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    assign glen  = i_len[{gidx, 2'b00} +: 4];
    assign o_gnt = found ? (NUM_REQ'(1) << gidx) : '0;

    assign o_byte_ready = en && !rst && !eos_seen && !i_clear
                          && (level_q <= LW'(WIN - 8));
    assign push = i_byte_valid && o_byte_ready;

    assign sh     = found ? LW'(glen) : (i_align ? LW'(level_q[2:0]) : '0);
    assign rem    = level_q - sh;
    assign win_sh = win_q << sh;
    // New byte lands directly below the bits that survive the shift.
    assign ins    = push ? ({i_byte, {(WIN-8){1'b0}}} >> rem) : '0;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        level_d = level_q;
        rr_d    = rr_q;
        under_d = under_q;
        cons_d  = cons_q;
        if (en) begin
            if (i_clear) begin
                win_d   = '0;
                level_d = '0;
                state_d = RUN;
                under_d = 1'b0;
            end else begin
                win_d   = win_sh | ins;
                level_d = rem + (push ? LW'(8) : '0);
                if (found) begin
                    rr_d   = gidx;
                    cons_d = cons_q + 32'(glen);
                end
                if (eos_seen && |short_req)
                    under_d = 1'b1;
                if (i_eos)
                    state_d = EOS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            win_q   <= '0;
            level_q <= '0;
            rr_q    <= PW'(NUM_REQ - 1);
            under_q <= 1'b0;
            cons_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            level_q <= level_d;
            rr_q    <= rr_d;
            under_q <= under_d;
            cons_q  <= cons_d;
        end
    end

    assign top  = win_q[WIN-1 -: 32];
    assign mask = (level_q >= LW'(32)) ? '1 : ~(32'hFFFF_FFFF >> level_q);

    assign o_window        = top & mask;
    assign o_window_valid  = (level_q >= LW'(32)) || eos_seen;
    assign o_level         = level_q;
    assign o_underrun      = under_q;
    assign o_bits_consumed = cons_q;

endmodule

// File: tb/tb_bitstream_window_arbiter.sv
// Bench for bitstream_window_arbiter: directed vector table, corner
// sequences and random traffic checked against a bit-queue model.
module tb_bitstream_window_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [7:0]   i_byte;
    logic         i_byte_valid, o_byte_ready;
    logic [N-1:0] i_req, o_gnt;
    logic [4*N-1:0] i_len;
    logic [31:0]  o_window;
    logic         o_window_valid;
    logic [6:0]   o_level;
    logic         i_align, i_clear, i_eos, o_underrun;
    logic [31:0]  o_bits_consumed;

    bitstream_window_arbiter #(.NUM_REQ(N), .WIN(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready),
        .i_req(i_req), .i_len(i_len), .o_gnt(o_gnt),
        .o_window(o_window), .o_window_valid(o_window_valid),
        .o_level(o_level), .i_align(i_align), .i_clear(i_clear),
        .i_eos(i_eos), .o_underrun(o_underrun),
        .o_bits_consumed(o_bits_consumed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: the window is a plain queue of bits, front = next bit.
    bit          mq[$];
    int          m_rr, m_g;
    bit          m_eos, m_under;
    logic [31:0] m_cons;

    function automatic void m_reset();
        mq.delete();
        m_rr    = N - 1;
        m_eos   = 0;
        m_under = 0;
        m_cons  = '0;
    endfunction

    logic [N-1:0] s_gnt;
    logic [6:0]   s_lvl;
    logic         s_rdy;
    logic [31:0]  s_win;

    task automatic cyc(input bit e, input bit bv, input logic [7:0] b,
                       input logic [N-1:0] rq, input logic [4*N-1:0] ln,
                       input bit al, input bit cl, input bit eo);
        int lv;
        int len;
        bit rdy;
        logic [N-1:0] g;
        logic [31:0] w;
        en = e; i_byte_valid = bv; i_byte = b;
        i_req = rq; i_len = ln;
        i_align = al; i_clear = cl; i_eos = eo;
        #1;
        lv = mq.size();
        w = '0;
        for (int i = 0; i < 32; i++)
            if (i < lv) w[31-i] = mq[i];
        rdy = e && !m_eos && !cl && (lv <= W - 8);
        m_g = -1;
        if (e && !al && !cl)
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (m_g < 0 && rq[k] && int'(ln[4*k +: 4]) <= lv) m_g = k;
            end
        g = '0;
        if (m_g >= 0) g[m_g] = 1'b1;
        chk("level", o_level, lv);
        chk("window", o_window, w);
        chk("wvalid", o_window_valid, (lv >= 32) || m_eos);
        chk("underrun", o_underrun, m_under);
        chk("consumed", o_bits_consumed, m_cons);
        chk("ready", o_byte_ready, rdy);
        chk("gnt", o_gnt, g);
        s_gnt = o_gnt; s_lvl = o_level; s_rdy = o_byte_ready; s_win = o_window;
        if (e) begin
            if (cl) begin
                mq.delete(); m_eos = 0; m_under = 0;
            end else begin
                if (m_eos)
                    for (int k = 0; k < N; k++)
                        if (rq[k] && int'(ln[4*k +: 4]) > lv) m_under = 1;
                if (m_g >= 0) begin
                    len = int'(ln[4*m_g +: 4]);
                    repeat (len) void'(mq.pop_front());
                    m_cons += 32'(len);
                    m_rr = m_g;
                end else if (al) begin
                    repeat (lv % 8) void'(mq.pop_front());
                end
                if (bv && rdy)
                    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
                if (eo) m_eos = 1;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          bv;
        logic [7:0]  b;
        logic [3:0]  rq;
        logic [15:0] ln;
        bit          al, cl, eo;
        logic [3:0]  gnt;
        logic [6:0]  lvl;
        bit          rdy;
        bit          cw;
        logic [31:0] win;
    } vec_t;

    vec_t tbl[37];
    logic [N-1:0]   rq_h;
    logic [4*N-1:0] ln_h;

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1, 8'(8'hA5 + i), 4'h0, 16'h0, 0, 0, 0,
                       4'h0, 7'(8 * i), 1, 0, 32'h0};
        tbl[8]  = '{0, 8'h00, 4'h1, 16'h0004, 0,0,0, 4'h1, 7'd64, 0, 0, 32'h0};
        tbl[9]  = '{0, 8'h00, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd60, 0, 1, 32'h5A6A7A8A};
        tbl[10] = '{0, 8'h00, 4'h7, 16'h0111, 0,0,0, 4'h2, 7'd60, 0, 0, 32'h0};
        tbl[11] = '{0, 8'h00, 4'h7, 16'h0111, 0,0,0, 4'h4, 7'd59, 0, 0, 32'h0};
        tbl[12] = '{0, 8'h00, 4'h7, 16'h0111, 0,0,0, 4'h1, 7'd58, 0, 0, 32'h0};
        tbl[13] = '{0, 8'h00, 4'h7, 16'h0111, 0,0,0, 4'h2, 7'd57, 0, 0, 32'h0};
        tbl[14] = '{0, 8'h00, 4'h7, 16'h0111, 0,0,0, 4'h4, 7'd56, 1, 0, 32'h0};
        tbl[15] = '{0, 8'h00, 4'h7, 16'h0111, 0,0,0, 4'h1, 7'd55, 1, 0, 32'h0};
        tbl[16] = '{0, 8'h00, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd54, 1, 0, 32'h0};
        tbl[17] = '{0, 8'h00, 4'h0, 16'h0000, 0,1,0, 4'h0, 7'd54, 0, 0, 32'h0};
        tbl[18] = '{1, 8'h12, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd0,  1, 0, 32'h0};
        tbl[19] = '{1, 8'h34, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd8,  1, 0, 32'h0};
        tbl[20] = '{0, 8'h00, 4'h1, 16'h0004, 0,0,0, 4'h1, 7'd16, 1, 0, 32'h0};
        tbl[21] = '{0, 8'h00, 4'h6, 16'h03D0, 0,0,0, 4'h4, 7'd12, 1, 0, 32'h0};
        tbl[22] = '{1, 8'h56, 4'h2, 16'h00D0, 0,0,0, 4'h0, 7'd9,  1, 0, 32'h0};
        tbl[23] = '{0, 8'h00, 4'h2, 16'h00D0, 0,0,0, 4'h2, 7'd17, 1, 0, 32'h0};
        tbl[24] = '{1, 8'h78, 4'h1, 16'h0004, 0,0,0, 4'h1, 7'd4,  1, 0, 32'h0};
        tbl[25] = '{1, 8'h9A, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd8,  1, 0, 32'h0};
        tbl[26] = '{0, 8'h00, 4'h8, 16'h3000, 0,0,0, 4'h8, 7'd16, 1, 0, 32'h0};
        tbl[27] = '{0, 8'h00, 4'h1, 16'h0001, 1,0,0, 4'h0, 7'd13, 1, 0, 32'h0};
        tbl[28] = '{1, 8'hBC, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd8,  1, 1, 32'h9A000000};
        tbl[29] = '{0, 8'h00, 4'h0, 16'h0000, 0,0,1, 4'h0, 7'd16, 1, 0, 32'h0};
        tbl[30] = '{0, 8'h00, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd16, 0, 1, 32'h9ABC0000};
        tbl[31] = '{0, 8'h00, 4'h1, 16'h0004, 0,0,0, 4'h1, 7'd16, 0, 0, 32'h0};
        tbl[32] = '{0, 8'h00, 4'h1, 16'h000F, 0,0,0, 4'h0, 7'd12, 0, 0, 32'h0};
        tbl[33] = '{0, 8'h00, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd12, 0, 1, 32'hABC00000};
        tbl[34] = '{0, 8'h00, 4'h0, 16'h0000, 0,1,0, 4'h0, 7'd12, 0, 0, 32'h0};
        tbl[35] = '{1, 8'hEF, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd0,  1, 0, 32'h0};
        tbl[36] = '{0, 8'h00, 4'h0, 16'h0000, 0,0,0, 4'h0, 7'd8,  1, 1, 32'hEF000000};

        rst = 1'b1; en = 1'b1; i_byte = 8'hFF; i_byte_valid = 1'b1;
        i_req = '1; i_len = '0; i_align = 0; i_clear = 0; i_eos = 0;
        @(negedge clk); #1;
        chk("rst_ready", o_byte_ready, 1'b0);
        chk("rst_gnt", o_gnt, 4'h0);
        @(negedge clk); #1;
        chk("rst_level", o_level, 7'd0);
        chk("rst_window", o_window, 32'h0);
        chk("rst_wvalid", o_window_valid, 1'b0);
        chk("rst_consumed", o_bits_consumed, 32'h0);
        chk("rst_underrun", o_underrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        for (int i = 0; i < 37; i++) begin
            cyc(1, tbl[i].bv, tbl[i].b, tbl[i].rq, tbl[i].ln,
                tbl[i].al, tbl[i].cl, tbl[i].eo);
            chk($sformatf("v%0d_gnt", i), s_gnt, tbl[i].gnt);
            chk($sformatf("v%0d_lvl", i), s_lvl, tbl[i].lvl);
            chk($sformatf("v%0d_rdy", i), s_rdy, tbl[i].rdy);
            if (tbl[i].cw)
                chk($sformatf("v%0d_win", i), s_win, tbl[i].win);
        end

        // Fill to 56, then push and consume a byte in the same cycle.
        for (int i = 0; i < 6; i++)
            cyc(1, 1, 8'(8'h10 + i), 4'h0, 16'h0, 0, 0, 0);
        cyc(1, 1, 8'hC3, 4'h1, 16'h0008, 0, 0, 0);
        chk("pg_gnt", s_gnt, 4'h1);
        chk("pg_rdy", s_rdy, 1'b1);
        chk("pg_lvl_before", s_lvl, 7'd56);
        cyc(0, 1, 8'h55, 4'h1, 16'h0001, 0, 0, 0);
        chk("pg_lvl_after", s_lvl, 7'd56);
        chk("en0_gnt", s_gnt, 4'h0);
        chk("en0_rdy", s_rdy, 1'b0);
        cyc(0, 1, 8'h55, 4'h1, 16'h0001, 1, 0, 1);
        chk("en0_hold", s_lvl, 7'd56);
        cyc(1, 0, 8'h00, 4'h1, 16'h000F, 0, 0, 0);
        cyc(1, 0, 8'h00, 4'h1, 16'h000F, 0, 0, 0);
        cyc(1, 0, 8'h00, 4'h1, 16'h000F, 0, 0, 0);
        cyc(1, 0, 8'h00, 4'h1, 16'h0003, 0, 0, 0);
        cyc(1, 0, 8'h00, 4'h0, 16'h0000, 0, 0, 0);
        chk("pg_bottom_lvl", s_lvl, 7'd8);
        chk("pg_bottom_byte", s_win[31:24], 8'hC3);

        rq_h = '0; ln_h = '0;
        for (int t = 0; t < 3000; t++) begin
            bit e, bv, al, cl, eo;
            e  = ($urandom_range(0, 15) != 0);
            bv = ($urandom_range(0, 9) < 7);
            al = ($urandom_range(0, 99) < 3);
            cl = ($urandom_range(0, 99) == 0);
            eo = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < N; k++)
                if (!rq_h[k] && $urandom_range(0, 3) == 0) begin
                    rq_h[k] = 1'b1;
                    ln_h[4*k +: 4] = 4'($urandom_range(0, 15));
                end
            if (t == 1500) begin
                rst = 1'b1;
                @(negedge clk); #1;
                chk("mid_rst_ready", o_byte_ready, 1'b0);
                chk("mid_rst_level", o_level, 7'd0);
                chk("mid_rst_underrun", o_underrun, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                m_reset();
            end
            cyc(e, bv, 8'($urandom), rq_h, ln_h, al, cl, eo);
            if (m_g >= 0) rq_h[m_g] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
